sram_rf_model: RTL and testbench
================================

Name: sram_rf_model

Overview:
- Behavioural model of a two-port register-file SRAM: one synchronous read port (A) and one synchronous write port (B), sharing a single clock.
- Hit-buffer wrappers use it for L1 hit storage, for example 4-bit triple-redundant hit copies or packed 4-hit words.
- Adds per-word valid tracking and status flags so benches can see reads of unwritten words and read/write collisions.

Parameters:
- wordwidth, 1, data bits per word.
- addrwidth, 9, address bits; depth = 2^addrwidth words. Every address is in range.

Ports:
- CLK  input  1  sole clock, shared by the read and write ports; rising edge.
- RST  input  1  synchronous, active-high reset.
- CENA  input  1  read-port enable, active low.
- AA  input  addrwidth  read address.
- QA  output  wordwidth  registered read data.
- E1A  output  1  collision flag, registered and aligned with QA.
- E2A  output  1  uninitialised-read flag, registered and aligned with QA.
- CENB  input  1  write-port enable, active low.
- AB  input  addrwidth  write address.
- DB  input  wordwidth  write data.
- EMAA  input  3  read margin adjust; ignored.
- EMAB  input  3  write margin adjust; ignored.
- RET1N  input  1  retention control, active low; 0 = retention.
- COLLDISN  input  1  collision-detection enable; 1 = detect.

Behaviour:
- Storage: mem[2^addrwidth] of wordwidth bits, plus valid[2^addrwidth] with 1 bit per word.
- Reset (RST=1 at posedge), highest priority:
  - QA<=0, E1A<=0, E2A<=0.
  - All valid bits <=0.
  - mem contents are not cleared.
  - Any write or read requested in that cycle is discarded.
- Write, at posedge when RST=0, RET1N=1, CENB=0: mem[AB]<=DB and valid[AB]<=1.
- Read, at posedge when RST=0, RET1N=1, CENA=0:
  - QA<=valid[AA] ? mem[AA] : 0, with 1-cycle latency; the value is seen after the edge that sampled CENA=0.
  - E2A<=!valid[AA].
  - E1A per the optional feature; otherwise 0.
- Read idle (CENA=1): QA holds its last value; E1A and E2A <=0.
- Same-cycle read and write to the same address (CENA=0, CENB=0, AA==AB): read-before-write.
  - QA returns the old content and the old valid state (0 with E2A=1 if not previously written).
  - The write still completes.
- Same-cycle read and write to different addresses: independent, no interaction.
- Retention (RET1N=0):
  - No write takes place; mem and valid hold.
  - QA holds; E1A and E2A <=0.
  - On return to RET1N=1, operation resumes on the next edge with contents intact.
- EMAA and EMAB have no functional effect.
- Addresses wrap naturally; there is no out-of-range case.
- X or Z on control inputs is not modelled; the bench drives known values.

Optional Feature:
- Macro: SRAM_RF_COLLISION_CHECK_EN.
- Defined:
  - At a posedge with RST=0, RET1N=1, CENA=0, CENB=0, AA==AB and COLLDISN=1, E1A<=1 for that read; QA still returns the old data.
  - With COLLDISN=0, E1A<=0 always.
  - E1A clears on any read without a collision, on idle, on reset and on retention.
- Not defined: E1A is tied to constant 0; COLLDISN is ignored. Read-before-write data behaviour is identical in both builds.

Test Plan:
1. wordwidth=4, addrwidth=9. RST pulse, then write DB=4'hA to AB=5, then read AA=5 -> QA=4'hA and E2A=0 one cycle after the read edge; QA holds 4'hA while CENA=1.
2. After reset, read AA=7 (never written) -> QA=0, E2A=1. Then write 4'h3 to address 7 and read again -> QA=4'h3, E2A=0.
3. Write 4'h1 to address 9; next cycle, read AA=9 and write DB=4'h6 to AB=9 in the same cycle -> QA=4'h1. With SRAM_RF_COLLISION_CHECK_EN and COLLDISN=1: E1A=1. With COLLDISN=0, or the macro undefined: E1A=0. A following read of 9 -> QA=4'h6.
4. Write 4'hF to address 2; assert RST together with a write of 4'h0 to address 2 and a read of address 2 -> QA=0, E1A=0, E2A=0, write discarded. Next read of 2 -> QA=0, E2A=1 (valid cleared).
5. RET1N=0 with CENB=0 writing 4'h5 to address 3 and CENA=0 reading address 3 -> QA unchanged, no write. Set RET1N=1 and read 3 -> previous content of 3 returned.
6. Sweep every address 0..511 with write data = address[3:0], then read back -> every QA matches the written value and E2A=0 throughout; EMAA/EMAB toggled randomly with no effect.

Source files
------------

// File: rtl/sram_rf_model_if.sv
// Port bundle for the two-port register-file SRAM model: read port A, write port B
// and the margin/retention/collision controls. Clock and reset stay outside.
interface sram_rf_model_if #(
  parameter int wordwidth = 1,
  parameter int addrwidth = 9
);
  logic                 CENA;
  logic [addrwidth-1:0] AA;
  logic [wordwidth-1:0] QA;
  logic                 E1A;
  logic                 E2A;
  logic                 CENB;
  logic [addrwidth-1:0] AB;
  logic [wordwidth-1:0] DB;
  logic [2:0]           EMAA;
  logic [2:0]           EMAB;
  logic                 RET1N;
  logic                 COLLDISN;

  modport master (
    output CENA, AA, CENB, AB, DB, EMAA, EMAB, RET1N, COLLDISN,
    input  QA, E1A, E2A
  );

  modport slave (
    input  CENA, AA, CENB, AB, DB, EMAA, EMAB, RET1N, COLLDISN,
    output QA, E1A, E2A
  );
endinterface

// File: rtl/sram_rf_model.sv
// Behavioural two-port register-file SRAM with per-word valid tracking and status flags.
// Optional collision flag on E1A is built when SRAM_RF_COLLISION_CHECK_EN is defined.
module sram_rf_model #(
  parameter int wordwidth = 1,
  parameter int addrwidth = 9
) (
  input logic             CLK,
  input logic             RST,
  sram_rf_model_if.slave  bus
);
  localparam int DEPTH = 1 << addrwidth;

  logic [wordwidth-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     validBits;

  logic [wordwidth-1:0] rdData_p1;
  logic                 collFlag_p1;
  logic                 uninitFlag_p1;

  logic                 active;
  logic                 rdReq;
  logic                 wrReq;
  logic                 collision;

  assign active = !RST && bus.RET1N;
  assign rdReq  = active && !bus.CENA;
  assign wrReq  = active && !bus.CENB;

`ifdef SRAM_RF_COLLISION_CHECK_EN
  assign collision = !bus.CENB && (bus.AA == bus.AB) && bus.COLLDISN;
  logic unusedInputs;
  assign unusedInputs = ^{bus.EMAA, bus.EMAB};
`else
  assign collision = 1'b0;
  logic unusedInputs;
  assign unusedInputs = ^{bus.EMAA, bus.EMAB, bus.COLLDISN};
`endif

  // Storage array: contents survive reset and retention.
  always_ff @(posedge CLK) begin
    if (wrReq) begin
      mem[bus.AB] <= bus.DB;
    end
  end

  // Valid bits and read port; reads see pre-write state (read-before-write).
  always_ff @(posedge CLK) begin
    if (RST) begin
      validBits     <= '0;
      rdData_p1     <= '0;
      collFlag_p1   <= 1'b0;
      uninitFlag_p1 <= 1'b0;
    end else begin
      if (wrReq) begin
        validBits[bus.AB] <= 1'b1;
      end
      if (rdReq) begin
        rdData_p1     <= validBits[bus.AA] ? mem[bus.AA] : '0;
        uninitFlag_p1 <= !validBits[bus.AA];
        collFlag_p1   <= collision;
      end else begin
        uninitFlag_p1 <= 1'b0;
        collFlag_p1   <= 1'b0;
      end
    end
  end

  assign bus.QA  = rdData_p1;
  assign bus.E1A = collFlag_p1;
  assign bus.E2A = uninitFlag_p1;
endmodule

// File: tb/tb_sram_rf_model.sv
// Directed scoreboard bench for sram_rf_model (wordwidth=4, addrwidth=9).
module tb_sram_rf_model;
`ifdef SRAM_RF_COLLISION_CHECK_EN
  localparam logic COLL = 1'b1;
`else
  localparam logic COLL = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sram_rf_model_if #(.wordwidth(4), .addrwidth(9)) bus ();

  sram_rf_model #(.wordwidth(4), .addrwidth(9)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0] q;
    logic       e1;
    logic       e2;
    string      name;
  } exp_t;

  exp_t sb[$];
  logic pend = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Drive one cycle of stimulus on the falling edge; optionally queue the expected response.
  task automatic cyc(input logic r, input logic ret, input logic cena, input logic [8:0] aa,
                     input logic cenb, input logic [8:0] ab, input logic [3:0] db,
                     input logic colld, input logic chk, input logic [3:0] eq,
                     input logic ee1, input logic ee2, input string nm);
    exp_t e;
    @(negedge CLK);
    RST          = r;
    bus.RET1N    = ret;
    bus.CENA     = cena;
    bus.AA       = aa;
    bus.CENB     = cenb;
    bus.AB       = ab;
    bus.DB       = db;
    bus.COLLDISN = colld;
    bus.EMAA     = 3'($urandom_range(7));
    bus.EMAB     = 3'($urandom_range(7));
    pend         = chk;
    if (chk) begin
      e.q = eq; e.e1 = ee1; e.e2 = ee2; e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [3:0] d);
    cyc(1'b0, 1'b1, 1'b1, 9'd0, 1'b0, a, d, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "");
  endtask

  task automatic rd(input logic [8:0] a, input logic [3:0] eq, input logic ee2, input string nm);
    cyc(1'b0, 1'b1, 1'b0, a, 1'b1, 9'd0, 4'h0, 1'b1, 1'b1, eq, 1'b0, ee2, nm);
  endtask

  // Monitor: every edge with a queued expectation is compared just after the edge.
  initial begin
    logic c;
    exp_t e;
    forever begin
      @(posedge CLK);
      c = pend;
      #1;
      if (c) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: response seen with no expectation queued");
        end else begin
          e = sb.pop_front();
          checks += 2;
          if (bus.QA !== e.q) begin
            errors++;
            $display("FAIL %s QA: got %h expected %h", e.name, bus.QA, e.q);
          end
          if (bus.E1A !== e.e1) begin
            errors++;
            $display("FAIL %s E1A: got %b expected %b", e.name, bus.E1A, e.e1);
          end
          if (bus.E2A !== e.e2) begin
            errors++;
            $display("FAIL %s E2A: got %b expected %b", e.name, bus.E2A, e.e2);
          end
        end
      end
    end
  end

  initial begin
    bus.CENA = 1'b1; bus.CENB = 1'b1; bus.AA = '0; bus.AB = '0; bus.DB = '0;
    bus.EMAA = '0; bus.EMAB = '0; bus.RET1N = 1'b1; bus.COLLDISN = 1'b1;

    // 1: reset, write then read, hold while idle
    cyc(1'b1, 1'b1, 1'b1, 9'd0, 1'b1, 9'd0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, "reset");
    wr(9'd5, 4'hA);
    rd(9'd5, 4'hA, 1'b0, "read5");
    cyc(1'b0, 1'b1, 1'b1, 9'd0, 1'b1, 9'd0, 4'h0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, "idle_hold");
    cyc(1'b0, 1'b1, 1'b1, 9'd0, 1'b1, 9'd0, 4'h0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, "idle_hold2");

    // 2: uninitialised read, then write and read again
    rd(9'd7, 4'h0, 1'b1, "uninit7");
    wr(9'd7, 4'h3);
    rd(9'd7, 4'h3, 1'b0, "read7");

    // 3: read-before-write collisions with detection on and off
    wr(9'd9, 4'h1);
    cyc(1'b0, 1'b1, 1'b0, 9'd9, 1'b0, 9'd9, 4'h6, 1'b1, 1'b1, 4'h1, COLL, 1'b0, "coll9_on");
    rd(9'd9, 4'h6, 1'b0, "after_coll9");
    wr(9'd10, 4'h1);
    cyc(1'b0, 1'b1, 1'b0, 9'd10, 1'b0, 9'd10, 4'h7, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, "coll10_off");
    rd(9'd10, 4'h7, 1'b0, "after_coll10");
    cyc(1'b0, 1'b1, 1'b0, 9'd11, 1'b0, 9'd11, 4'h2, 1'b1, 1'b1, 4'h0, COLL, 1'b1, "coll11_uninit");
    cyc(1'b0, 1'b1, 1'b0, 9'd10, 1'b0, 9'd12, 4'h4, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, "diff_addr");
    rd(9'd12, 4'h4, 1'b0, "read12");

    // 4: reset discards same-cycle write/read and clears valid bits
    wr(9'd2, 4'hF);
    cyc(1'b1, 1'b1, 1'b0, 9'd2, 1'b0, 9'd2, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, "reset_rw");
    rd(9'd2, 4'h0, 1'b1, "post_reset2");
    rd(9'd5, 4'h0, 1'b1, "post_reset5");

    // 5: retention blocks write, holds QA
    wr(9'd3, 4'hC);
    rd(9'd3, 4'hC, 1'b0, "read3");
    cyc(1'b0, 1'b0, 1'b0, 9'd3, 1'b0, 9'd3, 4'h5, 1'b1, 1'b1, 4'hC, 1'b0, 1'b0, "retention");
    rd(9'd7, 4'h0, 1'b1, "uninit7b");
    rd(9'd3, 4'hC, 1'b0, "after_ret3");

    // 6: full sweep
    for (int a = 0; a < 512; a++) wr(9'(a), 4'(a));
    for (int a = 0; a < 512; a++) rd(9'(a), 4'(a), 1'b0, "sweep");

    cyc(1'b0, 1'b1, 1'b1, 9'd0, 1'b1, 9'd0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "");
    @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
